// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with TX and RX FIFOs, configurable frame format and parity.
// Errored or overflowing RX frames are dropped and reported as single-cycle pulses.
module uart_fifo_core #(
  parameter int BPS_NUM    = 1296,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  output logic          uart_tx,
  input  logic          loopback,
  input  logic [7:0]    tx_data,
  input  logic          tx_wr_en,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  output logic          tx_busy,
  output logic [7:0]    rx_data,
  input  logic          rx_rd_en,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          rx_ovf,
  output logic          parity_err,
  output logic          frame_err
);

  localparam int CNT_W = $clog2(STOP_BITS * BPS_NUM + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BPS_NUM - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BPS_NUM / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * BPS_NUM - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [AW:0]      FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam bit               HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e           txState_q, rxState_q;
  logic [CNT_W-1:0] txCnt_q, rxCnt_q;
  logic [2:0]       txBit_q, rxBit_q;
  logic [7:0]       txShift_q;
  logic             txPar_q, txLine_q;
  logic [DATA_BITS-1:0] rxShift_q;
  logic             rxPar_q;
  logic             rxMeta_q, rxSync_q, rxPrev_q;
  logic             loopback_q;
  logic             rxOvf_q, parityErr_q, frameErr_q;

  logic [7:0]  txMem_q [FIFO_DEPTH];
  logic [7:0]  rxMem_q [FIFO_DEPTH];
  logic [AW-1:0] txWrPtr_q, txRdPtr_q, rxWrPtr_q, rxRdPtr_q;
  logic [AW:0]   txLevel_q, rxLevel_q;

  logic       txPush, txPop, txFrameEnd;
  logic       rxPush, rxPop, rxFull, rxStopSample, rxExpPar, rxParBad;
  logic       rxIn;
  logic [7:0] txHead;

  assign tx_full  = (txLevel_q == FULL_LVL);
  assign tx_level = txLevel_q;
  assign tx_busy  = (txState_q != S_IDLE) || (txLevel_q != '0);
  assign rx_empty = (rxLevel_q == '0);
  assign rx_level = rxLevel_q;
  assign rx_data  = rx_empty ? 8'h00 : rxMem_q[rxRdPtr_q];
  assign rx_ovf     = rxOvf_q;
  assign parity_err = parityErr_q;
  assign frame_err  = frameErr_q;
  assign uart_tx  = loopback_q ? 1'b1 : txLine_q;
  assign rxIn     = loopback_q ? txLine_q : uart_rx;

  assign txHead     = txMem_q[txRdPtr_q] & DATA_MASK;
  assign txPush     = tx_wr_en && !tx_full;
  assign txFrameEnd = (txState_q == S_STOP) && (txCnt_q == STOP_END);
  // Popping at the end of STOP lets the next start bit follow with no idle gap.
  assign txPop      = (txLevel_q != '0) && ((txState_q == S_IDLE) || txFrameEnd);

  assign rxFull       = (rxLevel_q == FULL_LVL);
  assign rxPop        = rx_rd_en && !rx_empty;
  assign rxStopSample = (rxState_q == S_STOP) && (rxCnt_q == BIT_END);
  assign rxExpPar     = (PARITY == 1) ? ~^rxShift_q : ^rxShift_q;
  assign rxParBad     = HAS_PAR && (rxPar_q != rxExpPar);
  assign rxPush       = rxStopSample && rxSync_q && !rxParBad && !rxFull;

  always_ff @(posedge clk) begin
    if (txPush) txMem_q[txWrPtr_q] <= tx_data;
    if (rxPush) rxMem_q[rxWrPtr_q] <= 8'(rxShift_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      txLevel_q <= '0;
      rxWrPtr_q <= '0;
      rxRdPtr_q <= '0;
      rxLevel_q <= '0;
    end else begin
      if (txPush) txWrPtr_q <= txWrPtr_q + AW'(1);
      if (txPop)  txRdPtr_q <= txRdPtr_q + AW'(1);
      case ({txPush, txPop})
        2'b10:   txLevel_q <= txLevel_q + (AW+1)'(1);
        2'b01:   txLevel_q <= txLevel_q - (AW+1)'(1);
        default: txLevel_q <= txLevel_q;
      endcase
      if (rxPush) rxWrPtr_q <= rxWrPtr_q + AW'(1);
      if (rxPop)  rxRdPtr_q <= rxRdPtr_q + AW'(1);
      case ({rxPush, rxPop})
        2'b10:   rxLevel_q <= rxLevel_q + (AW+1)'(1);
        2'b01:   rxLevel_q <= rxLevel_q - (AW+1)'(1);
        default: rxLevel_q <= rxLevel_q;
      endcase
    end
  end

  // Loopback switches only while both directions are idle, so no frame is split across sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      loopback_q <= 1'b0;
      rxMeta_q   <= 1'b1;
      rxSync_q   <= 1'b1;
      rxPrev_q   <= 1'b1;
    end else begin
      if (txState_q == S_IDLE && rxState_q == S_IDLE) loopback_q <= loopback;
      rxMeta_q <= rxIn;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q <= S_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      txLine_q  <= 1'b1;
    end else begin
      case (txState_q)
        S_IDLE: begin
          if (txPop) begin
            txShift_q <= txHead;
            txPar_q   <= (PARITY == 1) ? ~^txHead : ^txHead;
            txLine_q  <= 1'b0;
            txCnt_q   <= '0;
            txState_q <= S_START;
          end
        end
        S_START: begin
          if (txCnt_q == BIT_END) begin
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txLine_q  <= txShift_q[0];
            txState_q <= S_DATA;
          end else txCnt_q <= txCnt_q + CNT_W'(1);
        end
        S_DATA: begin
          if (txCnt_q == BIT_END) begin
            txCnt_q <= '0;
            if (txBit_q == LAST_BIT) begin
              txLine_q  <= HAS_PAR ? txPar_q : 1'b1;
              txState_q <= HAS_PAR ? S_PAR : S_STOP;
            end else begin
              txBit_q   <= txBit_q + 3'd1;
              txShift_q <= txShift_q >> 1;
              txLine_q  <= txShift_q[1];
            end
          end else txCnt_q <= txCnt_q + CNT_W'(1);
        end
        S_PAR: begin
          if (txCnt_q == BIT_END) begin
            txCnt_q   <= '0;
            txLine_q  <= 1'b1;
            txState_q <= S_STOP;
          end else txCnt_q <= txCnt_q + CNT_W'(1);
        end
        S_STOP: begin
          if (txFrameEnd) begin
            txCnt_q <= '0;
            if (txPop) begin
              txShift_q <= txHead;
              txPar_q   <= (PARITY == 1) ? ~^txHead : ^txHead;
              txLine_q  <= 1'b0;
              txState_q <= S_START;
            end else txState_q <= S_IDLE;
          end else txCnt_q <= txCnt_q + CNT_W'(1);
        end
        default: txState_q <= S_IDLE;
      endcase
    end
  end

  // Only the first stop bit is checked; returning to IDLE mid-stop allows a prompt resync.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxState_q   <= S_IDLE;
      rxCnt_q     <= '0;
      rxBit_q     <= '0;
      rxShift_q   <= '0;
      rxPar_q     <= 1'b0;
      rxOvf_q     <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      rxOvf_q     <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (rxState_q)
        S_IDLE: begin
          if (rxPrev_q && !rxSync_q) begin
            rxCnt_q   <= '0;
            rxState_q <= S_START;
          end
        end
        S_START: begin
          if (rxCnt_q == HALF_END) begin
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxState_q <= rxSync_q ? S_IDLE : S_DATA;
          end else rxCnt_q <= rxCnt_q + CNT_W'(1);
        end
        S_DATA: begin
          if (rxCnt_q == BIT_END) begin
            rxCnt_q   <= '0;
            rxShift_q <= {rxSync_q, rxShift_q[DATA_BITS-1:1]};
            rxBit_q   <= rxBit_q + 3'd1;
            if (rxBit_q == LAST_BIT) rxState_q <= HAS_PAR ? S_PAR : S_STOP;
          end else rxCnt_q <= rxCnt_q + CNT_W'(1);
        end
        S_PAR: begin
          if (rxCnt_q == BIT_END) begin
            rxCnt_q   <= '0;
            rxPar_q   <= rxSync_q;
            rxState_q <= S_STOP;
          end else rxCnt_q <= rxCnt_q + CNT_W'(1);
        end
        S_STOP: begin
          if (rxStopSample) begin
            rxCnt_q   <= '0;
            rxState_q <= S_IDLE;
            if (!rxSync_q)     frameErr_q  <= 1'b1;
            else if (rxParBad) parityErr_q <= 1'b1;
            else if (rxFull)   rxOvf_q     <= 1'b1;
          end else rxCnt_q <= rxCnt_q + CNT_W'(1);
        end
        default: rxState_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: an 8N1 instance exercised through loopback, external wiring and
// bit-banged frames, plus an even-parity instance for the parity-error path.
module tb_uart_fifo_core;

  localparam int BPS   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rxDrv, extLoop, selB, monEn;

  logic       uartRxA, uartTxA, loopbackA, txWrEnA, txFullA, txBusyA;
  logic [7:0] txDataA, rxDataA;
  logic       rxRdEnA, rxEmptyA, rxOvfA, parErrA, frameErrA;
  logic [2:0] txLevelA, rxLevelA;

  logic       uartRxB, uartTxB, txFullB, txBusyB, rxEmptyB, rxOvfB, parErrB, frameErrB;
  logic [7:0] rxDataB;
  logic [2:0] txLevelB, rxLevelB;

  assign uartRxA = extLoop ? uartTxA : (selB ? 1'b1 : rxDrv);
  assign uartRxB = selB ? rxDrv : 1'b1;

  uart_fifo_core #(.BPS_NUM(BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutA (
    .clk(clk), .rst(rst), .uart_rx(uartRxA), .uart_tx(uartTxA), .loopback(loopbackA),
    .tx_data(txDataA), .tx_wr_en(txWrEnA), .tx_full(txFullA), .tx_level(txLevelA), .tx_busy(txBusyA),
    .rx_data(rxDataA), .rx_rd_en(rxRdEnA), .rx_empty(rxEmptyA), .rx_level(rxLevelA),
    .rx_ovf(rxOvfA), .parity_err(parErrA), .frame_err(frameErrA)
  );

  uart_fifo_core #(.BPS_NUM(BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutB (
    .clk(clk), .rst(rst), .uart_rx(uartRxB), .uart_tx(uartTxB), .loopback(1'b0),
    .tx_data(8'h00), .tx_wr_en(1'b0), .tx_full(txFullB), .tx_level(txLevelB), .tx_busy(txBusyB),
    .rx_data(rxDataB), .rx_rd_en(1'b0), .rx_empty(rxEmptyB), .rx_level(rxLevelB),
    .rx_ovf(rxOvfB), .parity_err(parErrB), .frame_err(frameErrB)
  );

  int nVec = 0;
  int nMiss = 0;
  int ovfCntA = 0, parCntA = 0, frmCntA = 0, parCntB = 0, frmCntB = 0;
  int popCnt = 0;
  logic [7:0] expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actVal, input logic [31:0] expVal);
    nVec++;
    if (actVal !== expVal) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actVal, expVal);
    end
  endtask

  task automatic timeoutFail(input string name);
    nVec++;
    nMiss++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Push one byte into the TX FIFO; optionally record it as an expected RX byte.
  task automatic applyStimulus(input logic [7:0] b, input bit expectRx);
    txDataA = b;
    txWrEnA = 1'b1;
    if (expectRx) expQ.push_back(b);
    @(negedge clk);
    txWrEnA = 1'b0;
  endtask

  task automatic waitTxIdle(input string name, input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      done = !txBusyA;
    end
    if (!done) timeoutFail(name);
  endtask

  task automatic waitDrained(input string name, input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      done = (expQ.size() == 0) && rxEmptyA;
    end
    if (!done) timeoutFail(name);
  endtask

  // Cycles the FSM spends on the line after popping a lone byte.
  task automatic measureFrame(output int cycles);
    bit done = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!txBusyA) done = 1'b1;
      else if (txLevelA == 3'd0) cycles++;
    end
    if (!done) timeoutFail("frame_len");
  endtask

  task automatic driveBit(input logic v);
    rxDrv = v;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic driveFrame(input logic [7:0] d, input bit withPar, input logic parBit, input logic stopVal);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    if (withPar) driveBit(parBit);
    driveBit(stopVal);
    rxDrv = 1'b1;
    repeat (2 * BPS) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      ovfCntA += int'(rxOvfA);
      parCntA += int'(parErrA);
      frmCntA += int'(frameErrA);
      parCntB += int'(parErrB);
      frmCntB += int'(frameErrB);
    end
  end

  // Scoreboard monitor: pops dutA's RX FIFO whenever it presents a byte and compares to the queue.
  initial begin
    rxRdEnA = 1'b0;
    forever begin
      @(negedge clk);
      if (monEn && !rst && !rxEmptyA) begin
        if (expQ.size() == 0) begin
          nVec++;
          nMiss++;
          $display("[TB] FAIL unexpected_rx: got 0x%0h, expected no byte", rxDataA);
        end else begin
          checkOutput("rx_data", {24'h0, rxDataA}, {24'h0, expQ.pop_front()});
        end
        popCnt++;
        rxRdEnA = 1'b1;
      end else begin
        rxRdEnA = 1'b0;
      end
    end
  end

  initial begin
    int cyc;
    int popBase;
    rst = 1'b1;
    rxDrv = 1'b1;
    extLoop = 1'b0;
    selB = 1'b0;
    monEn = 1'b1;
    loopbackA = 1'b0;
    txWrEnA = 1'b0;
    txDataA = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_uart_tx", {31'h0, uartTxA}, 32'h1);
    checkOutput("rst_tx_busy", {31'h0, txBusyA}, 32'h0);
    checkOutput("rst_tx_full", {31'h0, txFullA}, 32'h0);
    checkOutput("rst_rx_empty", {31'h0, rxEmptyA}, 32'h1);
    checkOutput("rst_levels", {26'h0, txLevelA, rxLevelA}, 32'h0);
    checkOutput("rst_rx_data", {24'h0, rxDataA}, 32'h0);
    checkOutput("rst_pulses", {29'h0, rxOvfA, parErrA, frameErrA}, 32'h0);

    $display("[TB] loopback 8N1");
    loopbackA = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(8'h55, 1'b1);
    measureFrame(cyc);
    checkOutput("frame_len_55", cyc, 160);
    applyStimulus(8'hA3, 1'b1);
    measureFrame(cyc);
    checkOutput("frame_len_A3", cyc, 160);
    checkOutput("lb_uart_tx_idle", {31'h0, uartTxA}, 32'h1);
    waitDrained("lb_drain", 200);
    checkOutput("lb_err_pulses", ovfCntA + parCntA + frmCntA, 0);

    $display("[TB] TX FIFO overfill");
    extLoop = 1'b1;
    loopbackA = 1'b0;
    repeat (4) @(negedge clk);
    popBase = popCnt;
    applyStimulus(8'h10, 1'b1);
    applyStimulus(8'h21, 1'b1);
    applyStimulus(8'h32, 1'b1);
    applyStimulus(8'h43, 1'b1);
    applyStimulus(8'h54, 1'b1);
    applyStimulus(8'h65, 1'b0);
    checkOutput("ovfill_tx_full", {31'h0, txFullA}, 32'h1);
    checkOutput("ovfill_tx_level", {29'h0, txLevelA}, DEPTH);
    waitTxIdle("ovfill_tx_idle", 1200);
    waitDrained("ovfill_drain", 200);
    repeat (4 * BPS) @(negedge clk);
    checkOutput("ovfill_frames", popCnt - popBase, DEPTH + 1);
    checkOutput("ovfill_tx_level_end", {29'h0, txLevelA}, 32'h0);
    extLoop = 1'b0;

    $display("[TB] even parity error");
    selB = 1'b1;
    driveFrame(8'h01, 1'b1, 1'b0, 1'b1);
    checkOutput("par_err_count", parCntB, 1);
    checkOutput("par_rx_level", {29'h0, rxLevelB}, 32'h0);
    driveFrame(8'h01, 1'b1, 1'b1, 1'b1);
    checkOutput("par_good_level", {29'h0, rxLevelB}, 32'h1);
    checkOutput("par_good_data", {24'h0, rxDataB}, 32'h01);
    checkOutput("par_err_count2", parCntB + 100 * frmCntB, 1);
    selB = 1'b0;

    $display("[TB] frame error and resync");
    driveFrame(8'hF0, 1'b0, 1'b0, 1'b0);
    checkOutput("frm_err_count", frmCntA, 1);
    checkOutput("frm_rx_level", {29'h0, rxLevelA}, 32'h0);
    expQ.push_back(8'h3C);
    driveFrame(8'h3C, 1'b0, 1'b0, 1'b1);
    waitDrained("frm_resync", 200);

    $display("[TB] RX overflow");
    monEn = 1'b0;
    loopbackA = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h44, 1'b1);
    waitTxIdle("ovf_fill", 1000);
    repeat (4) @(negedge clk);
    checkOutput("ovf_full_level", {29'h0, rxLevelA}, DEPTH);
    applyStimulus(8'h7E, 1'b0);
    waitTxIdle("ovf_extra", 400);
    repeat (4) @(negedge clk);
    checkOutput("ovf_pulse_count", ovfCntA, 1);
    checkOutput("ovf_level", {29'h0, rxLevelA}, DEPTH);
    checkOutput("ovf_head", {24'h0, rxDataA}, 32'h11);
    monEn = 1'b1;
    waitDrained("ovf_drain", 200);

    $display("[TB] reset mid-frame and RX glitch");
    loopbackA = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(8'h5A, 1'b0);
    applyStimulus(8'h96, 1'b0);
    repeat (BPS + 2 * BPS + 5) @(negedge clk);
    checkOutput("mid_tx_level", {29'h0, txLevelA}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_uart_tx", {31'h0, uartTxA}, 32'h1);
    checkOutput("mid_rst_tx_level", {29'h0, txLevelA}, 32'h0);
    checkOutput("mid_rst_tx_busy", {31'h0, txBusyA}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rxDrv = 1'b0;
    @(negedge clk);
    rxDrv = 1'b1;
    repeat (3 * BPS) @(negedge clk);
    checkOutput("glitch_rx_level", {29'h0, rxLevelA}, 32'h0);
    checkOutput("glitch_pulses", ovfCntA * 100 + parCntA * 10 + frmCntA, 101);
    checkOutput("post_rst_tx_idle", {30'h0, uartTxA, txBusyA}, 32'h2);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
